// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU / debug loader) arbiter in front of a single-port
// RAM with combinational read data. One access per ACCESS/RESP pair.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          valid0,
  output logic          valid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  output logic          ram_en,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e        state_q, state_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          arb_go;
  logic          arb_win;

`ifdef ARB_ROUND_ROBIN_EN
  logic          last_q, last_d;
`endif

  // Arbitration: possible in every non-ACCESS cycle; lone requester wins
  always_comb begin
    arb_go  = (state_q != ACCESS) && (req0 || req1);
    arb_win = !req0;
`ifdef ARB_ROUND_ROBIN_EN
    if (req0 && req1) arb_win = !last_q;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RESP: state_d = arb_go ? ACCESS : IDLE;
      ACCESS:     state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  // Command latch and read-data capture
  always_comb begin
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (arb_go) begin
      win_d   = arb_win;
      we_d    = arb_win ? we1    : we0;
      addr_d  = arb_win ? addr1  : addr0;
      wdata_d = arb_win ? wdata1 : wdata0;
    end
    if ((state_q == ACCESS) && !we_q) begin
      if (win_q) rdata1_d = ram_dout;
      else       rdata0_d = ram_dout;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin pointer remembers the most recently granted port
  always_comb begin
    last_d = arb_go ? arb_win : last_q;
  end

  // Pointer register; reset value makes port 0 preferred first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs decoded from state and latched command only
  always_comb begin
    gnt0   = (state_q == ACCESS) && !win_q;
    gnt1   = (state_q == ACCESS) &&  win_q;
    valid0 = (state_q == RESP)   && !win_q;
    valid1 = (state_q == RESP)   &&  win_q;
    ram_en = (state_q == ACCESS) &&  we_q;
    busy   = (state_q == ACCESS);
  end

  // Latched command only changes on entry to ACCESS, so it also holds outside it
  assign ram_ad  = addr_q;
  assign ram_din = wdata_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked each cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, valid0, valid1, ram_en, busy;
  logic [DW-1:0] rdata0, rdata1, ram_din, ram_dout;
  logic [AW-1:0] ram_ad;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_en(ram_en), .ram_dout(ram_dout),
    .busy(busy)
  );

  // Behavioural RAM: combinational read, write on the clock edge
  logic [DW-1:0] ram [64];
  assign ram_dout = ram[ram_ad];
  always @(posedge clk) if (ram_en) ram[ram_ad] <= ram_din;

  // Reference model state
  typedef struct {
    bit            act;
    bit            win;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t          m_acc, m_resp;
  bit            m_last;
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] exp_rd [2];
  logic [AW-1:0] exp_ad;
  logic [DW-1:0] exp_din;
  int unsigned   n_checks = 0, n_errors = 0;
  int unsigned   g_cnt0 = 0, g_cnt1 = 0, v_cnt1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc  = '{default: '0};
    m_resp = '{default: '0};
    m_last = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    exp_ad  = '0;
    exp_din = '0;
  endtask

  // Called mid-cycle: commit the access completed at the last edge, check this
  // cycle's outputs, then decide the grant for the next cycle.
  task automatic model_step();
    cmd_t nxt;
    bit   w;
    if (m_resp.act) begin
      if (m_resp.we) ref_mem[m_resp.addr] = m_resp.data;
      else           exp_rd[m_resp.win]   = ref_mem[m_resp.addr];
    end
    check("gnt0",    gnt0,    m_acc.act && !m_acc.win);
    check("gnt1",    gnt1,    m_acc.act &&  m_acc.win);
    check("valid0",  valid0,  m_resp.act && !m_resp.win);
    check("valid1",  valid1,  m_resp.act &&  m_resp.win);
    check("ram_en",  ram_en,  m_acc.act && m_acc.we);
    check("busy",    busy,    m_acc.act);
    check("rdata0",  rdata0,  exp_rd[0]);
    check("rdata1",  rdata1,  exp_rd[1]);
    check("ram_ad",  ram_ad,  exp_ad);
    check("ram_din", ram_din, exp_din);
    g_cnt0 += gnt0;
    g_cnt1 += gnt1;
    v_cnt1 += valid1;
    m_resp = m_acc;
    nxt = '{default: '0};
    if (!m_acc.act && (req0 || req1)) begin
      w = (req0 && req1) ? (RR ? !m_last : 1'b0) : req1;
      nxt = '{1'b1, w, w ? we1 : we0, w ? addr1 : addr0, w ? wdata1 : wdata0};
      m_last  = w;
      exp_ad  = nxt.addr;
      exp_din = nxt.data;
    end
    m_acc = nxt;
  endtask

  // Advance one cycle; returns just after the next rising edge
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    check("rst_ctrl",   {gnt1, gnt0, valid1, valid0, ram_en, busy}, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_ram_ad", ram_ad, 0);
    check("rst_ram_din", ram_din, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_port(input int p, input bit r, input bit we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  // Hold a request until granted (bounded), then drop it; ends in the ACCESS cycle
  task automatic issue(input int p, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int unsigned ticks);
    logic g;
    drive_port(p, 1'b1, we, a, d);
    ticks = 0;
    g = 1'b0;
    while (!g && ticks < 8) begin
      tick();
      ticks++;
      g = (p == 0) ? gnt0 : gnt1;
    end
    if (!g) check("gnt_timeout", g, 1);
    drive_port(p, 1'b0, we, a, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned   t;
    logic [DW-1:0] v, saved;
    bit            pend [2];

    for (int i = 0; i < 64; i++) begin
      v = DW'($urandom);
      ram[i] <= v;
      ref_mem[i] = v;
    end
    #2;
    apply_reset();

    // Write BEEF to 5 then read it back; grant one cycle after the request
    issue(0, 1'b1, 6'd5, 16'hBEEF, t);
    check("beef_gnt_lat", t, 1);
    check("beef_ram_en", ram_en, 1);
    tick();
    check("beef_wr_valid0", valid0, 1);
    issue(0, 1'b0, 6'd5, 16'h0000, t);
    tick();
    check("beef_rd_valid0", valid0, 1);
    check("beef_rdata0", rdata0, 16'hBEEF);
    tick();

    // Port 1 writes 63, port 0 reads it at the next arbitration point
    saved = rdata1;
    issue(1, 1'b1, 6'd63, 16'h1234, t);
    issue(0, 1'b0, 6'd63, 16'h0000, t);
    tick();
    check("raw63_rdata0", rdata0, 16'h1234);
    check("raw63_rdata1", rdata1, saved);
    tick();

    // One-cycle req1 pulse entirely inside a port-0 ACCESS is ignored
    issue(0, 1'b0, 6'd7, 16'h0000, t);
    g_cnt1 = 0;
    v_cnt1 = 0;
    drive_port(1, 1'b1, 1'b1, 6'd9, 16'hDEAD);
    tick();
    drive_port(1, 1'b0, 1'b0, 6'd0, 16'h0000);
    repeat (4) tick();
    check("pulse_gnt1", g_cnt1, 0);
    check("pulse_valid1", v_cnt1, 0);

    // Reset during ACCESS of a write aborts it
    issue(0, 1'b1, 6'd2, 16'h5555, t);
    repeat (2) tick();
    issue(0, 1'b1, 6'd2, 16'hAAAA, t);
    check("abort_busy_pre", busy, 1);
    apply_reset();
    issue(0, 1'b0, 6'd2, 16'h0000, t);
    tick();
    check("abort_rdata0", rdata0, 16'h5555);
    tick();

    // Both ports requesting continuously from a fresh reset
    apply_reset();
    g_cnt0 = 0;
    g_cnt1 = 0;
    drive_port(0, 1'b1, 1'b0, 6'd1, 16'h0000);
    drive_port(1, 1'b1, 1'b0, 6'd3, 16'h0000);
    repeat (20) tick();
    check("hold_gnt0", g_cnt0, RR ? 5 : 10);
    check("hold_gnt1", g_cnt1, RR ? 5 : 0);
    drive_port(0, 1'b0, 1'b0, 6'd0, 16'h0000);
    drive_port(1, 1'b0, 1'b0, 6'd0, 16'h0000);
    repeat (3) tick();

    // Randomized traffic on both ports
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            drive_port(p, 1'b1, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 7)),
                       DW'($urandom));
            pend[p] = 1'b1;
          end else begin
            drive_port(p, 1'b0, 1'b0, 6'd0, 16'h0000);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          drive_port(p, 1'b0, 1'b0, 6'd0, 16'h0000);
          pend[p] = 1'b0;
        end
      end
      tick();
      if (gnt0) pend[0] = 1'b0;
      if (gnt1) pend[1] = 1'b0;
    end
    drive_port(0, 1'b0, 1'b0, 6'd0, 16'h0000);
    drive_port(1, 1'b0, 1'b0, 6'd0, 16'h0000);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
